// File: rtl/i2s_master_tx.sv
// ---------------------------------------------------------------------------
// i2s_master_tx
//   I2S bus-master transmitter. Derives sclk_out from clk_in with a
//   programmable divider, drives ws_out, and shifts stereo samples out MSB
//   first on sdata_out. Data and word select only change on sclk falling
//   edges, so a receiver samples on the sclk rising edge. Samples enter
//   through a one-deep valid/ready holding register and are consumed once
//   per stereo frame (2*WIDTH sclk periods).
//
// Parameters
//   WIDTH    bits per channel
//   CLK_DIV  clk_in cycles per sclk half-period (>= 1)
//
// Ports
//   clk_in          system clock, rising edge
//   rst             asynchronous active-high reset
//   left_i/right_i  two's complement channel samples
//   sample_valid_i  samples valid
//   sample_ready_o  holding register empty (accept on valid & ready)
//   sclk_out        I2S bit clock
//   ws_out          word select (0 = left, 1 = right), leads MSB by one sclk
//   sdata_out       serial data, MSB first
//   frame_start_o   one-clk pulse on every frame load
//   underrun_o      one-clk pulse when a frame loads with holding empty
//
// Optional feature (macro I2S_TX_HOLD_LAST_EN)
//   Defined:   an underrun load repeats the last successfully loaded frame.
//   Undefined: an underrun load transmits zeros.
// ---------------------------------------------------------------------------
module i2s_master_tx #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] left_i,
  input  logic [WIDTH-1:0] right_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  output logic             sclk_out,
  output logic             ws_out,
  output logic             sdata_out,
  output logic             frame_start_o,
  output logic             underrun_o
);

  localparam int FRAME_W = 2 * WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WS_LO    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] WS_HI    = CNT_W'(FRAME_W - 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_sclk;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] r_hold;
  logic               r_full;
  logic               r_ready;
  logic               r_ws;
  logic               r_sdata;
  logic               r_frame_start;
  logic               r_underrun;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [FRAME_W-1:0] r_last;
`endif

  logic               w_div_wrap;
  logic               w_fall;
  logic [CNT_W-1:0]   w_bit_next;
  logic               w_load;
  logic               w_accept;
  logic               w_full_next;
  logic               w_ws_next;
  logic [FRAME_W-1:0] w_load_word;
  logic [FRAME_W-1:0] w_shift_next;

  // Stage: divider / fall-event decode and next-state of the serializer
  always_comb begin
    w_div_wrap   = (r_div_cnt == DIV_LAST);
    // A fall event is the wrap that takes sclk from 1 back to 0.
    w_fall       = w_div_wrap & r_sclk;
    w_bit_next   = (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
    w_load       = w_fall & (w_bit_next == '0);
    w_accept     = sample_valid_i & r_ready;
    // Ready is only high while empty, so an accept never collides with a
    // full register; a load empties it unless a new sample arrives.
    w_full_next  = w_accept | (r_full & ~w_load);
    w_ws_next    = (w_bit_next >= WS_LO) && (w_bit_next <= WS_HI);
`ifdef I2S_TX_HOLD_LAST_EN
    w_load_word  = r_full ? r_hold : r_last;
`else
    w_load_word  = r_full ? r_hold : '0;
`endif
    w_shift_next = w_load ? w_load_word : {r_shift[FRAME_W-2:0], 1'b0};
  end

  // Stage: registered state and outputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_div_cnt     <= '0;
      r_sclk        <= 1'b0;
      r_bit_cnt     <= LAST_BIT;
      r_shift       <= '0;
      r_hold        <= '0;
      r_full        <= 1'b0;
      r_ready       <= 1'b1;
      r_ws          <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
      r_last        <= '0;
`endif
    end else begin
      r_div_cnt     <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
      if (w_div_wrap) begin
        r_sclk <= ~r_sclk;
      end
      r_frame_start <= w_load;
      r_underrun    <= w_load & ~r_full;
      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_shift   <= w_shift_next;
        r_ws      <= w_ws_next;
        r_sdata   <= w_shift_next[FRAME_W-1];
      end
      // Same-cycle load and accept: the load above has already taken the
      // old (empty) contents; the new sample waits for the next frame.
      if (w_accept) begin
        r_hold <= {left_i, right_i};
      end
      r_full  <= w_full_next;
      r_ready <= ~w_full_next;
`ifdef I2S_TX_HOLD_LAST_EN
      if (w_load & r_full) begin
        r_last <= r_hold;
      end
`endif
    end
  end

  assign sample_ready_o = r_ready;
  assign sclk_out       = r_sclk;
  assign ws_out         = r_ws;
  assign sdata_out      = r_sdata;
  assign frame_start_o  = r_frame_start;
  assign underrun_o     = r_underrun;

endmodule

// File: tb/tb_i2s_master_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_master_tx
//   Directed sequence with randomized sample data/valid against a frame-level
//   reference model: output timing is computed arithmetically from the cycle
//   count since reset release, and sample flow from a holding-slot model.
// ---------------------------------------------------------------------------
module tb_i2s_master_tx;

  localparam int WIDTH = 16;
  localparam int CD    = 2;
  localparam int FW    = 2 * WIDTH;
  localparam int FRAME = FW * 2 * CD;   // clk_in cycles per stereo frame
`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD_LAST = 1'b1;
`else
  localparam bit HOLD_LAST = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] left_i = '0;
  logic [WIDTH-1:0] right_i = '0;
  logic             sample_valid_i = 1'b0;
  logic             sample_ready_o;
  logic             sclk_out;
  logic             ws_out;
  logic             sdata_out;
  logic             frame_start_o;
  logic             underrun_o;

  i2s_master_tx #(.WIDTH(WIDTH), .CLK_DIV(CD)) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .left_i         (left_i),
    .right_i        (right_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .sclk_out       (sclk_out),
    .ws_out         (ws_out),
    .sdata_out      (sdata_out),
    .frame_start_o  (frame_start_o),
    .underrun_o     (underrun_o)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int          n;          // rising edges since reset release
  bit          m_full;
  logic [31:0] m_hold, m_frame, m_last;
  logic        e_sclk, e_ws, e_sdata, e_fs, e_ur, e_ready;
  bit          last_acc, last_load;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
  endtask

  task automatic model_reset();
    n       = 0;
    m_full  = 1'b0;
    m_hold  = '0;
    m_frame = '0;
    m_last  = '0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_sclk"},  32'(sclk_out),       32'd0);
    chk({tag, "_ws"},    32'(ws_out),         32'd0);
    chk({tag, "_sdata"}, 32'(sdata_out),      32'd0);
    chk({tag, "_fs"},    32'(frame_start_o),  32'd0);
    chk({tag, "_ur"},    32'(underrun_o),     32'd0);
    chk({tag, "_rdy"},   32'(sample_ready_o), 32'd1);
  endtask

  // One clk_in cycle: advance the model across the edge, then compare.
  task automatic step();
    bit acc, load;
    int k, b;
    @(posedge clk_in);
    acc  = sample_valid_i && !m_full;
    n++;
    k    = n / (2 * CD);                       // fall events so far
    load = (n % (2 * CD) == 0) && ((k - 1) % FW == 0);
    e_ur = 1'b0;
    if (load) begin
      e_ur = !m_full;
      if (m_full) begin
        m_frame = m_hold;
        m_last  = m_hold;
      end else begin
        m_frame = HOLD_LAST ? m_last : 32'd0;
      end
      m_full = 1'b0;
    end
    if (acc) begin
      m_hold = {left_i, right_i};
      m_full = 1'b1;
    end
    e_fs    = load;
    e_ready = !m_full;
    e_sclk  = ((n / CD) % 2) == 1;
    if (k == 0) begin
      e_ws    = 1'b0;
      e_sdata = 1'b0;
    end else begin
      b       = (k - 1) % FW;
      e_ws    = (b >= WIDTH - 1) && (b <= FW - 2);
      e_sdata = m_frame[FW-1-b];
    end
    last_acc  = acc;
    last_load = load;
    #1;
    chk("sclk",  32'(sclk_out),       32'(e_sclk));
    chk("ws",    32'(ws_out),         32'(e_ws));
    chk("sdata", 32'(sdata_out),      32'(e_sdata));
    chk("fs",    32'(frame_start_o),  32'(e_fs));
    chk("ur",    32'(underrun_o),     32'(e_ur));
    chk("ready", 32'(sample_ready_o), 32'(e_ready));
  endtask

  // Asynchronous reset asserted mid-cycle; called from #1 after an edge.
  task automatic reset_mid(input string tag);
    #2 rst = 1'b1;
    #1 chk_reset_values(tag);
    @(posedge clk_in);
    @(posedge clk_in);
    #3 rst = 1'b0;
    model_reset();
  endtask

  task automatic new_data();
    left_i  = 16'($urandom);
    right_i = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, wsv;
    int          rises, acc_cnt, ur_cnt;
    bit          started, prev_sclk, found;

    // ---- Power-on reset, no samples supplied ----
    model_reset();
    @(posedge clk_in);
    @(posedge clk_in);
    #1 chk_reset_values("por");
    #2 rst = 1'b0;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      step();
      if (n == 2 * CD) begin
        chk("first_load_fs", 32'(frame_start_o), 32'd1);
        chk("first_load_ur", 32'(underrun_o),    32'd1);
      end
    end

    // ---- Known sample before first load, recovered on sclk rise ----
    reset_mid("rst_a");
    left_i = 16'hA5C3; right_i = 16'h3C5A; sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    rx = '0; wsv = '0; rises = 0; started = 1'b0; prev_sclk = sclk_out;
    for (int i = 0; i < 2 * FRAME && rises < FW; i++) begin
      step();
      if (frame_start_o) started = 1'b1;
      if (started && sclk_out && !prev_sclk) begin
        rx         = {rx[30:0], sdata_out};
        wsv[rises] = ws_out;
        rises++;
      end
      prev_sclk = sclk_out;
    end
    chk("rx_bits",  32'(rises),  32'(FW));
    chk("rx_left",  32'(rx[31:16]), 32'h0000A5C3);
    chk("rx_right", 32'(rx[15:0]),  32'h00003C5A);
    chk("rx_ws",    wsv,          32'h7FFF8000);

    // ---- Back-to-back source ----
    new_data();
    sample_valid_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (last_acc) new_data();
      found = frame_start_o;
    end
    chk("b2b_sync", 32'(found), 32'd1);
    acc_cnt = 0; ur_cnt = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      bit obs_acc;
      obs_acc = sample_valid_i && sample_ready_o;
      step();
      if (obs_acc) begin
        acc_cnt++;
        new_data();
      end
      if (underrun_o) ur_cnt++;
    end
    chk("b2b_accepts",   32'(acc_cnt), 32'd4);
    chk("b2b_underruns", 32'(ur_cnt),  32'd0);
    sample_valid_i = 1'b0;

    // ---- Valid arrives on the very edge of a load with holding empty ----
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      step();
      found = !m_full && ((n + 1) % (2 * CD) == 0) && (((n + 1) / (2 * CD) - 1) % FW == 0);
    end
    chk("align_found", 32'(found), 32'd1);
    new_data();
    sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    chk("same_clk_fs",   32'(frame_start_o),  32'd1);
    chk("same_clk_ur",   32'(underrun_o),     32'd1);
    chk("same_clk_held", 32'(sample_ready_o), 32'd0);
    for (int i = 0; i < FRAME; i++) step();
    chk("next_frame_fs", 32'(frame_start_o), 32'd1);
    chk("next_frame_ur", 32'(underrun_o),    32'd0);

    // ---- Random valid pattern and data ----
    for (int i = 0; i < 6 * FRAME; i++) begin
      new_data();
      sample_valid_i = ($urandom_range(0, 7) == 0);
      step();
    end
    sample_valid_i = 1'b0;

    // ---- Reset in the middle of a frame (bit 20) ----
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      found = (n % (2 * CD) == 0) && ((n / (2 * CD) - 1) % FW == 20);
    end
    chk("bit20_found", 32'(found), 32'd1);
    step();
    reset_mid("rst_mid");
    for (int i = 0; i < 2 * CD; i++) step();
    chk("restart_fs", 32'(frame_start_o), 32'd1);
    chk("restart_ws", 32'(ws_out),        32'd0);
    for (int i = 0; i < 8; i++) step();

    // ---- Single sample then starvation (hold-last behaviour) ----
    reset_mid("rst_b");
    left_i = 16'h1234; right_i = 16'h8001; sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (n == 2 * CD + FRAME) begin
        chk("starve_fs", 32'(frame_start_o), 32'd1);
        chk("starve_ur", 32'(underrun_o),    32'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
